eth_latency_log_reader: RTL and testbench

- Read-side counterpart of the Ethernet latency log record path.
- The record path writes eth_latency_stats_struct entries (start_timestamp, end_timestamp) into a circular log RAM. This block serves host/control read requests against that RAM.
- Each request is bounds-checked against the current fill level. The block issues the RAM read, computes latency = end - start, and returns one response on a val/rdy stream.
- Sits between the log RAM read port and the control/readout logic.

---
 rtl/eth_latency_log_reader_pkg.sv | 27 ++
 rtl/eth_latency_log_reader_ctrl.sv | 87 ++++++++
 rtl/eth_latency_log_reader_datap.sv | 37 +++
 rtl/eth_latency_log_reader.sv | 70 +++++++
 tb/tb_eth_latency_log_reader.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/eth_latency_log_reader_pkg.sv
// Shared types for the latency log read path.
package eth_latency_log_reader_pkg;

  localparam int unsigned PKT_TIMESTAMP_W = 64;
  localparam int unsigned LOG_DEPTH_LOG2_DEF = 10;
  localparam int unsigned LOG_CNT_W = LOG_DEPTH_LOG2_DEF + 1;

  // One log record as written by the record path.
  typedef struct packed {
    logic [PKT_TIMESTAMP_W-1:0] start_timestamp;
    logic [PKT_TIMESTAMP_W-1:0] end_timestamp;
  } eth_latency_stats_struct;

  typedef enum logic {
    READ_IDX  = 1'b0,
    READ_META = 1'b1
  } rd_cmd_e;

  // Registered response payload.
  typedef struct packed {
    logic                       err;
    eth_latency_stats_struct    entry;
    logic [PKT_TIMESTAMP_W-1:0] latency;
    logic [LOG_CNT_W-1:0]       num_entries;
  } eth_lat_rd_resp_struct;

endpackage

// File: rtl/eth_latency_log_reader_ctrl.sv
// Request/response FSM, bounds check and RAM read issue.
module eth_latency_log_reader_ctrl
  import eth_latency_log_reader_pkg::*;
#(
  parameter int unsigned LOG_DEPTH_LOG2 = LOG_DEPTH_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_req_val,
  input  logic                      rd_req_cmd,
  input  logic [LOG_DEPTH_LOG2-1:0] rd_req_addr,
  output logic                      rd_req_rdy,
  input  logic [LOG_DEPTH_LOG2-1:0] log_wr_ptr,
  input  logic                      log_has_wrapped,
  output logic                      log_rd_req_val,
  output logic [LOG_DEPTH_LOG2-1:0] log_rd_req_addr,
  output logic                      rd_resp_val,
  input  logic                      rd_resp_rdy,
  output logic                      accept,
  output logic                      accept_imm,
  output logic                      imm_err,
  output logic                      capture_ram,
  output logic [LOG_DEPTH_LOG2:0]   num_valid
);

  localparam int unsigned CNT_W = LOG_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** LOG_DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_e;

  state_e  state, state_next;
  rd_cmd_e cmd;
  logic    in_range;

  assign cmd       = rd_cmd_e'(rd_req_cmd);
  assign num_valid = log_has_wrapped ? CNT_W'(DEPTH) : {1'b0, log_wr_ptr};
  assign in_range  = {1'b0, rd_req_addr} < num_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, handshakes and datapath load strobes.
  always_comb begin
    state_next      = state;
    rd_req_rdy      = 1'b0;
    rd_resp_val     = 1'b0;
    log_rd_req_val  = 1'b0;
    log_rd_req_addr = rd_req_addr;
    accept          = 1'b0;
    accept_imm      = 1'b0;
    imm_err         = 1'b0;
    capture_ram     = 1'b0;
    case (state)
      IDLE: begin
        rd_req_rdy = 1'b1;
        if (rd_req_val) begin
          accept = 1'b1;
          if (cmd == READ_IDX && in_range) begin
            log_rd_req_val = 1'b1;
            state_next     = RAM_WAIT;
          end else begin
            accept_imm = 1'b1;
            imm_err    = (cmd == READ_IDX);
            state_next = RESP;
          end
        end
      end
      RAM_WAIT: begin
        capture_ram = 1'b1;
        state_next  = RESP;
      end
      RESP: begin
        rd_resp_val = 1'b1;
        if (rd_resp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/eth_latency_log_reader_datap.sv
// Response registers and latency subtractor.
module eth_latency_log_reader_datap
  import eth_latency_log_reader_pkg::*;
#(
  parameter int unsigned LOG_DEPTH_LOG2 = LOG_DEPTH_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    accept,
  input  logic                    accept_imm,
  input  logic                    imm_err,
  input  logic                    capture_ram,
  input  logic [LOG_DEPTH_LOG2:0] num_valid,
  input  eth_latency_stats_struct log_rd_resp_data,
  output eth_lat_rd_resp_struct   resp
);

  // Load count at acceptance, then either immediate or RAM-sourced payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp <= '0;
    end else begin
      if (accept) resp.num_entries <= LOG_CNT_W'(num_valid);
      if (accept_imm) begin
        resp.err     <= imm_err;
        resp.entry   <= '0;
        resp.latency <= '0;
      end
      if (capture_ram) begin
        resp.err     <= 1'b0;
        resp.entry   <= log_rd_resp_data;
        resp.latency <= log_rd_resp_data.end_timestamp - log_rd_resp_data.start_timestamp;
      end
    end
  end

endmodule

// File: rtl/eth_latency_log_reader.sv
// Read-side server for the Ethernet latency log RAM.
module eth_latency_log_reader
  import eth_latency_log_reader_pkg::*;
#(
  parameter int unsigned LOG_DEPTH_LOG2 = LOG_DEPTH_LOG2_DEF,
  parameter int unsigned TS_W           = PKT_TIMESTAMP_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_req_val,
  input  logic                      rd_req_cmd,
  input  logic [LOG_DEPTH_LOG2-1:0] rd_req_addr,
  output logic                      rd_req_rdy,
  input  logic [LOG_DEPTH_LOG2-1:0] log_wr_ptr,
  input  logic                      log_has_wrapped,
  output logic                      log_rd_req_val,
  output logic [LOG_DEPTH_LOG2-1:0] log_rd_req_addr,
  input  eth_latency_stats_struct   log_rd_resp_data,
  output logic                      rd_resp_val,
  input  logic                      rd_resp_rdy,
  output logic                      rd_resp_err,
  output eth_latency_stats_struct   rd_resp_entry,
  output logic [TS_W-1:0]           rd_resp_latency,
  output logic [LOG_DEPTH_LOG2:0]   rd_resp_num_entries
);

  localparam int unsigned CNT_W = LOG_DEPTH_LOG2 + 1;

  logic                    accept, accept_imm, imm_err, capture_ram;
  logic [LOG_DEPTH_LOG2:0] num_valid;
  eth_lat_rd_resp_struct   resp;

  eth_latency_log_reader_ctrl #(.LOG_DEPTH_LOG2(LOG_DEPTH_LOG2)) u_ctrl (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_req_val      (rd_req_val),
    .rd_req_cmd      (rd_req_cmd),
    .rd_req_addr     (rd_req_addr),
    .rd_req_rdy      (rd_req_rdy),
    .log_wr_ptr      (log_wr_ptr),
    .log_has_wrapped (log_has_wrapped),
    .log_rd_req_val  (log_rd_req_val),
    .log_rd_req_addr (log_rd_req_addr),
    .rd_resp_val     (rd_resp_val),
    .rd_resp_rdy     (rd_resp_rdy),
    .accept          (accept),
    .accept_imm      (accept_imm),
    .imm_err         (imm_err),
    .capture_ram     (capture_ram),
    .num_valid       (num_valid)
  );

  eth_latency_log_reader_datap #(.LOG_DEPTH_LOG2(LOG_DEPTH_LOG2)) u_datap (
    .clk              (clk),
    .rst_n            (rst_n),
    .accept           (accept),
    .accept_imm       (accept_imm),
    .imm_err          (imm_err),
    .capture_ram      (capture_ram),
    .num_valid        (num_valid),
    .log_rd_resp_data (log_rd_resp_data),
    .resp             (resp)
  );

  assign rd_resp_err         = resp.err;
  assign rd_resp_entry       = resp.entry;
  assign rd_resp_latency     = TS_W'(resp.latency);
  assign rd_resp_num_entries = CNT_W'(resp.num_entries);

endmodule

// File: tb/tb_eth_latency_log_reader.sv
// Directed plus randomized checks of the log reader against a reference model.
module tb_eth_latency_log_reader;
  import eth_latency_log_reader_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned TS    = PKT_TIMESTAMP_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    rd_req_val;
  logic                    rd_req_cmd;
  logic [AW-1:0]           rd_req_addr;
  logic                    rd_req_rdy;
  logic [AW-1:0]           log_wr_ptr;
  logic                    log_has_wrapped;
  logic                    log_rd_req_val;
  logic [AW-1:0]           log_rd_req_addr;
  eth_latency_stats_struct log_rd_resp_data;
  logic                    rd_resp_val;
  logic                    rd_resp_rdy;
  logic                    rd_resp_err;
  eth_latency_stats_struct rd_resp_entry;
  logic [TS-1:0]           rd_resp_latency;
  logic [AW:0]             rd_resp_num_entries;

  int checks = 0;
  int errors = 0;

  eth_latency_stats_struct ram [DEPTH];

  eth_latency_log_reader #(.LOG_DEPTH_LOG2(AW), .TS_W(TS)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rd_req_val          (rd_req_val),
    .rd_req_cmd          (rd_req_cmd),
    .rd_req_addr         (rd_req_addr),
    .rd_req_rdy          (rd_req_rdy),
    .log_wr_ptr          (log_wr_ptr),
    .log_has_wrapped     (log_has_wrapped),
    .log_rd_req_val      (log_rd_req_val),
    .log_rd_req_addr     (log_rd_req_addr),
    .log_rd_resp_data    (log_rd_resp_data),
    .rd_resp_val         (rd_resp_val),
    .rd_resp_rdy         (rd_resp_rdy),
    .rd_resp_err         (rd_resp_err),
    .rd_resp_entry       (rd_resp_entry),
    .rd_resp_latency     (rd_resp_latency),
    .rd_resp_num_entries (rd_resp_num_entries)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data one cycle after the read enable.
  always @(posedge clk) begin
    if (log_rd_req_val) log_rd_resp_data <= ram[log_rd_req_addr];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check the whole transaction against the model.
  task automatic do_req(input logic cmd, input logic [AW-1:0] addr, input logic [AW-1:0] wp,
                        input logic wrapped, input int hold);
    int unsigned nv;
    logic        exp_err;
    logic        exp_rd;
    eth_latency_stats_struct exp_entry;
    logic [TS-1:0] exp_lat;
    int          exp_delay;
    int          cyc;
    logic        snap_err;
    eth_latency_stats_struct snap_entry;
    logic [TS-1:0] snap_lat;
    logic [AW:0] snap_num;

    nv        = wrapped ? DEPTH : int'(wp);
    exp_rd    = (cmd == 1'b0) && (int'(addr) < nv);
    exp_err   = (cmd == 1'b0) && !exp_rd;
    exp_entry = exp_rd ? ram[addr] : '0;
    exp_lat   = exp_rd ? ram[addr].end_timestamp - ram[addr].start_timestamp : '0;
    exp_delay = exp_rd ? 2 : 1;

    rd_req_val = 1'b1; rd_req_cmd = cmd; rd_req_addr = addr;
    log_wr_ptr = wp; log_has_wrapped = wrapped; rd_resp_rdy = 1'b0;
    #1;
    chk("req_rdy_idle", 256'(rd_req_rdy), 256'(1));
    chk("log_rd_val", 256'(log_rd_req_val), 256'(exp_rd));
    if (exp_rd) chk("log_rd_addr", 256'(log_rd_req_addr), 256'(addr));
    @(posedge clk);
    @(negedge clk);
    rd_req_val = 1'b0;
    log_wr_ptr = AW'($urandom);
    log_has_wrapped = 1'($urandom);
    cyc = 1;
    while (!rd_resp_val && cyc < 8) begin
      chk("no_rd_in_wait", 256'(log_rd_req_val), 256'(0));
      @(negedge clk);
      cyc++;
    end
    chk("resp_delay", 256'(cyc), 256'(exp_delay));
    chk("resp_err", 256'(rd_resp_err), 256'(exp_err));
    chk("resp_entry", 256'(rd_resp_entry), 256'(exp_entry));
    chk("resp_lat", 256'(rd_resp_latency), 256'(exp_lat));
    chk("resp_num", 256'(rd_resp_num_entries), 256'(nv));
    snap_err = rd_resp_err; snap_entry = rd_resp_entry;
    snap_lat = rd_resp_latency; snap_num = rd_resp_num_entries;
    for (int i = 0; i < hold; i++) begin
      rd_req_val = 1'b1;
      @(negedge clk);
      chk("hold_val", 256'(rd_resp_val), 256'(1));
      chk("hold_req_rdy", 256'(rd_req_rdy), 256'(0));
      chk("hold_fields", {snap_err, snap_entry, snap_lat, snap_num},
                         {rd_resp_err, rd_resp_entry, rd_resp_latency, rd_resp_num_entries});
    end
    rd_req_val = 1'b0;
    rd_resp_rdy = 1'b1;
    @(negedge clk);
    rd_resp_rdy = 1'b0;
    chk("post_val", 256'(rd_resp_val), 256'(0));
    chk("post_req_rdy", 256'(rd_req_rdy), 256'(1));
  endtask

  // Reset during RAM_WAIT (depth=1) or RESP (depth=2).
  task automatic reset_mid(input int depth);
    rd_req_val = 1'b1; rd_req_cmd = 1'b0; rd_req_addr = AW'(2);
    log_wr_ptr = AW'(5); log_has_wrapped = 1'b0; rd_resp_rdy = 1'b0;
    @(posedge clk);
    for (int i = 0; i < depth; i++) begin
      @(negedge clk);
      rd_req_val = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_val", 256'(rd_resp_val), 256'(0));
    chk("rst_mid_num", 256'(rd_resp_num_entries), 256'(0));
    rst_n = 1'b1;
    rd_resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_nostale", 256'(rd_resp_val), 256'(0));
      chk("rst_mid_rdy", 256'(rd_req_rdy), 256'(1));
    end
    rd_resp_rdy = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i].start_timestamp = {$urandom, $urandom};
      ram[i].end_timestamp   = {$urandom, $urandom};
    end
    ram[3].start_timestamp = TS'(100);
    ram[3].end_timestamp   = TS'(250);
    ram[7].start_timestamp = '1 - TS'(9);
    ram[7].end_timestamp   = TS'(5);

    rst_n = 1'b0; rd_req_val = 1'b0; rd_req_cmd = 1'b0; rd_req_addr = '0;
    log_wr_ptr = '0; log_has_wrapped = 1'b0; rd_resp_rdy = 1'b0;
    log_rd_resp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_val", 256'(rd_resp_val), 256'(0));
    chk("rst_err", 256'(rd_resp_err), 256'(0));
    chk("rst_entry", 256'(rd_resp_entry), 256'(0));
    chk("rst_lat", 256'(rd_resp_latency), 256'(0));
    chk("rst_num", 256'(rd_resp_num_entries), 256'(0));
    chk("rst_logrd", 256'(log_rd_req_val), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 256'(rd_req_rdy), 256'(1));

    do_req(1'b0, AW'(3), AW'(5), 1'b0, 0);
    do_req(1'b0, AW'(5), AW'(5), 1'b0, 0);
    do_req(1'b0, AW'(0), AW'(0), 1'b0, 0);
    do_req(1'b0, AW'(1023), AW'(0), 1'b1, 0);
    do_req(1'b1, AW'(17), AW'(0), 1'b1, 0);
    do_req(1'b1, AW'(0), AW'(9), 1'b0, 0);
    do_req(1'b0, AW'(7), AW'(8), 1'b0, 0);
    do_req(1'b0, AW'(3), AW'(5), 1'b0, 7);
    do_req(1'b0, AW'(9), AW'(5), 1'b0, 7);

    reset_mid(1);
    reset_mid(2);

    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] wp;
      logic [AW-1:0] a;
      wp = AW'($urandom);
      a  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, int'(wp))) : AW'($urandom);
      do_req(1'($urandom_range(0, 3) == 0), a, wp, 1'($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
